// File: rtl/ecg_phase_nco.sv
// Phase accumulator NCO driving the ECG waveform LUT. Beat rate is set by the tuning word;
// new tuning words are staged in a shadow register and only take effect on a beat boundary.
module ecg_phase_nco #(
   parameter int unsigned      ACC_W   = 24,
   parameter int unsigned      PHASE_W = 8,
   parameter logic [ACC_W-1:0] FTW_RST = 24'h010000,
   parameter int unsigned      CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               trig,
   input  logic [ACC_W-1:0]   ftw_in,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   output logic [PHASE_W-1:0] phase,
   output logic               phase_valid,
   output logic               beat_sync,
   output logic [CNT_W-1:0]   beat_cnt,
   output logic               busy
);

   typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   ftw_q, ftw_d;
   logic [ACC_W-1:0]   shadow_q, shadow_d;
   logic               pending_q, pending_d;
   logic               mode_q, mode_d;
   logic               sync_q, sync_d;
   logic               pvalid_q, pvalid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [ACC_W:0]     sum;
   logic               carry;
   logic               ftw_zero;
   logic               xfer;

   always_comb begin
      sum       = {1'b0, acc_q} + {1'b0, ftw_q};
      carry     = sum[ACC_W];
      ftw_zero  = (ftw_q == '0);
      xfer      = ftw_valid & ~pending_q;

      state_d   = state_q;
      acc_d     = acc_q;
      ftw_d     = ftw_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      mode_d    = mode_q;
      sync_d    = 1'b0;
      pvalid_d  = 1'b0;
      cnt_d     = cnt_q;

      case (state_q)
         StIdle: begin
            acc_d = '0;
            if (xfer) ftw_d = ftw_in;
            if (mode ? trig : en) begin
               state_d  = StRun;
               mode_d   = mode;
               acc_d    = ftw_q;
               pvalid_d = 1'b1;
            end
         end
         StRun, StStop: begin
            pvalid_d = 1'b1;
            acc_d    = sum[ACC_W-1:0];
            if (state_q == StRun) begin
               if (mode_q) begin
                  if (carry) state_d = StIdle;
               end else if (!en) begin
                  // Stopping right on a boundary already leaves the waveform at baseline.
                  state_d = carry ? StIdle : StStop;
               end
            end else if (en) begin
               state_d = StRun;
            end else if (carry || ftw_zero) begin
               state_d = StIdle;
            end

            if (carry) begin
               sync_d = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end

            if (state_d == StIdle) begin
               acc_d     = '0;
               pending_d = 1'b0;
               if (xfer) ftw_d = ftw_in;
               else if (pending_q) ftw_d = shadow_q;
            end else if (ftw_zero) begin
               // Frozen accumulator has no boundary to wait for.
               if (xfer) ftw_d = ftw_in;
            end else begin
               if (carry && pending_q) begin
                  ftw_d     = shadow_q;
                  pending_d = 1'b0;
               end
               if (xfer) begin
                  shadow_d  = ftw_in;
                  pending_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         ftw_q     <= FTW_RST;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         mode_q    <= 1'b0;
         sync_q    <= 1'b0;
         pvalid_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         ftw_q     <= ftw_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         mode_q    <= mode_d;
         sync_q    <= sync_d;
         pvalid_q  <= pvalid_d;
         cnt_q     <= cnt_d;
      end
   end

   assign phase       = acc_q[ACC_W-1 -: PHASE_W];
   assign phase_valid = pvalid_q;
   assign beat_sync   = sync_q;
   assign beat_cnt    = cnt_q;
   assign ftw_ready   = ~pending_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: doc/ecg_phase_nco.md
Name: ecg_phase_nco

Overview:
- Numerically controlled phase accumulator that produces the 8-bit phase word consumed by the ECG/sine lookup stage.
- Sets beat rate (heart rate) through a frequency tuning word (FTW).
- Supports continuous and single-beat modes, glitch-free FTW updates at beat boundaries, a beat-boundary strobe and a beat counter.
- Sits directly upstream of the waveform LUT; its phase output connects straight to the LUT phase input.

Parameters:
- ACC_W, 24, accumulator width in bits (≥ PHASE_W+1).
- PHASE_W, 8, output phase width; phase = top PHASE_W bits of the accumulator.
- FTW_RST, 24'h010000, active FTW after reset.
- CNT_W, 16, beat counter width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-low.
- en  in  1  continuous-mode run request (level).
- mode  in  1  0 = continuous, 1 = single beat.
- trig  in  1  single-beat start pulse, sampled in IDLE only.
- ftw_in  in  ACC_W  new tuning word.
- ftw_valid  in  1  ftw_in valid.
- ftw_ready  out  1  shadow register can accept an FTW.
- phase  out  PHASE_W  phase to the LUT stage (acc[ACC_W-1 -: PHASE_W]).
- phase_valid  out  1  high while the accumulator is advancing (RUN/STOPPING).
- beat_sync  out  1  one-cycle strobe on the cycle phase shows the post-wrap value.
- beat_cnt  out  CNT_W  completed beats, saturating.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst=0 at clk edge):
  - acc=0, phase=0, phase_valid=0, beat_sync=0, beat_cnt=0, busy=0.
  - ftw_active=FTW_RST, shadow pending=0, ftw_ready=1, state=IDLE.
  - Reset mid-beat aborts immediately with no final beat_sync.
- Accumulator:
  - {carry, acc_next} = acc + ftw_active, computed at ACC_W+1 bits; carry=1 defines a wrap.
  - acc, beat_sync and phase_valid are registered, so phase lags the state decision by 1 cycle.
- FSM:
  - IDLE:
    - acc held at 0.
    - mode=0 & en=1 -> RUN.
    - mode=1 & trig=1 -> RUN.
    - First advancing edge loads acc=ftw_active.
  - RUN:
    - acc <= acc_next every cycle.
    - On a wrap: beat_sync=1 next cycle and beat_cnt++ (held at all-ones).
    - mode=1 & wrap -> IDLE, acc forced to 0 (beat_sync still pulses).
    - mode=0 & en=0 -> STOPPING.
  - STOPPING:
    - Keeps advancing until a wrap, then -> IDLE with acc=0 (waveform ends at baseline); that wrap still counts and strobes.
    - en=1 again before the wrap -> back to RUN with no discontinuity.
    - If ftw_active==0, -> IDLE on the next cycle.
  - mode changes are honoured only in IDLE; mode is latched on the IDLE->RUN transition.
- FTW handshake (valid/ready, transfer on ftw_valid & ftw_ready):
  - IDLE: ftw_in is written directly to ftw_active on the transfer edge; ftw_ready stays 1.
  - RUN/STOPPING: ftw_in is captured into shadow, pending=1, ftw_ready=0 from the next cycle. On the next wrap, ftw_active<=shadow, pending=0, ftw_ready=1 on the following cycle.
  - A transfer in the same cycle as a wrap applies at the following wrap, not the current one.
  - A pending shadow on RUN->IDLE is applied on entering IDLE.
- ftw_active=0 in RUN: phase frozen, no wraps; FTW updates are then applied immediately (no boundary exists).
- trig outside IDLE and en in mode=1 are ignored.
- Beat period = ceil(2^ACC_W / ftw_active) cycles, with ±1-cycle jitter for non-power-of-2 FTW.

Test Plan:
1. Reset then FTW_RST=0x010000, mode=0, en=1: phase steps 1/cycle → 0x01..0xFF,0x00. beat_sync at cycle 256 after start, beat_cnt=1; after 1024 cycles beat_cnt=4.
2. mode=1, ftw_in=0x100000 loaded in IDLE, trig pulse:
   - phase → 0x10,0x20..0xF0,0x00.
   - single beat_sync, busy low after 16 cycles, acc=0, beat_cnt=1.
   - a second trig during the beat is ignored.
3. Running at 0x010000, push ftw_in=0x020000 at phase 0x40: ftw_ready drops next cycle; step stays 1 until wrap, then 2/cycle; ftw_ready=1 one cycle after wrap. A second push during pending stalls (no transfer).
4. Deassert en at phase 0x80 (ftw 0x010000): phase continues to 0x00, beat_sync pulses, busy falls, phase holds 0. Re-assert en at 0xC0 instead: no stop, no glitch.
5. Force beat_cnt near saturation (ftw 0x800000, 2 cycles/beat, run 2^17 cycles) → beat_cnt holds 0xFFFF.
6. Drive rst=0 at phase 0x77 in RUN with a pending FTW: next cycle phase=0, beat_cnt=0, ftw_active=0x010000, ftw_ready=1, no beat_sync.
